// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
package uart_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_ID,
    ST_LEN,
    ST_PAY,
    ST_CKS,
    ST_SEND,
    ST_WAIT
  } state_e;

  localparam logic [7:0] HDR0_BYTE   = 8'hAA;
  localparam logic [7:0] HDR1_BYTE   = 8'h55;
  localparam int         ID_W        = 3;
  localparam int         FRAME_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester picker. The pointer holds the first index searched and
// advances past the source whose frame just completed.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N_SRC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             upd,
  input  logic [ID_W-1:0]  upd_idx,
  output logic [N_SRC-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic [ID_W-1:0] ptr;
  logic            found;
  int              j;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (upd_idx == ID_W'(N_SRC - 1)) ? '0 : upd_idx + 1'b1;
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      for (int i = 0; i < N_SRC; i++) begin
        if (!found && (i == j) && req[i]) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Shares the UART upload FIFO among N_SRC sources, one framed packet at a time.
// Define UART_SCHED_CKSUM_EN to append the XOR checksum byte to every frame.
//
// state | meaning
// IDLE  | wait for uart_rdy and any request, then grant the RR winner
// HDR0  | write 0xAA
// HDR1  | write 0x55
// ID    | write source index
// LEN   | write clamped payload length
// PAY   | stream payload bytes from the granted source
// CKS   | write XOR of ID, LEN and payload
// SEND  | one-cycle uart_send pulse
// WAIT  | hold grant until uart_send_done
module uart_frame_sched
  import uart_sched_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int MAX_LEN = 64
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       req,
  input  logic [8*N_SRC-1:0]     req_len,
  input  logic [8*N_SRC-1:0]     pl_data,
  output logic [N_SRC-1:0]       grant,
  output logic                   pl_rd,
  output logic [N_SRC-1:0]       src_done,
  output logic [7:0]             wFIFO_idata,
  output logic                   wFIFO_wrreq,
  input  logic                   wFIFO_full,
  output logic                   uart_send,
  input  logic                   uart_send_done,
  input  logic                   uart_rdy,
  output logic                   len_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

`ifdef UART_SCHED_CKSUM_EN
  localparam state_e ST_TAIL = ST_CKS;
`else
  localparam state_e ST_TAIL = ST_SEND;
`endif

  state_e           state, state_nxt;
  logic [N_SRC-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx, idx;
  logic [7:0]       len, cnt, req_len_sel, len_clamp, pl_byte;
  logic             clamp, start, frame_end;

  assign start     = (state == ST_IDLE) && uart_rdy && (|req);
  assign frame_end = (state == ST_WAIT) && uart_send_done;

  rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .clk     (clk_50m),
    .rst_n   (rst_n),
    .req     (req),
    .upd     (frame_end),
    .upd_idx (idx),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    req_len_sel = '0;
    pl_byte     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (arb_idx == ID_W'(i)) req_len_sel = req_len[8*i +: 8];
      if (idx == ID_W'(i))     pl_byte     = pl_data[8*i +: 8];
    end
  end

  assign clamp     = req_len_sel > 8'(MAX_LEN);
  assign len_clamp = clamp ? 8'(MAX_LEN) : req_len_sel;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

`ifdef UART_SCHED_CKSUM_EN
  logic [7:0] cks;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      cks <= '0;
    end else if (start) begin
      cks <= 8'(arb_idx) ^ len_clamp;
    end else if (state == ST_PAY && wFIFO_wrreq) begin
      cks <= cks ^ pl_byte;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    wFIFO_wrreq = 1'b0;
    wFIFO_idata = '0;
    pl_rd       = 1'b0;
    uart_send   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_HDR0;
      ST_HDR0: begin
        wFIFO_idata = HDR0_BYTE;
        wFIFO_wrreq = !wFIFO_full;
        if (!wFIFO_full) state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        wFIFO_idata = HDR1_BYTE;
        wFIFO_wrreq = !wFIFO_full;
        if (!wFIFO_full) state_nxt = ST_ID;
      end
      ST_ID: begin
        wFIFO_idata = 8'(idx);
        wFIFO_wrreq = !wFIFO_full;
        if (!wFIFO_full) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        wFIFO_idata = len;
        wFIFO_wrreq = !wFIFO_full;
        if (!wFIFO_full) state_nxt = (len == 8'd0) ? ST_TAIL : ST_PAY;
      end
      ST_PAY: begin
        wFIFO_idata = pl_byte;
        wFIFO_wrreq = !wFIFO_full;
        pl_rd       = !wFIFO_full;
        if (!wFIFO_full && cnt == 8'd1) state_nxt = ST_TAIL;
      end
`ifdef UART_SCHED_CKSUM_EN
      ST_CKS: begin
        wFIFO_idata = cks;
        wFIFO_wrreq = !wFIFO_full;
        if (!wFIFO_full) state_nxt = ST_SEND;
      end
`endif
      ST_SEND: begin
        uart_send = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (uart_send_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      grant     <= '0;
      idx       <= '0;
      len       <= '0;
      cnt       <= '0;
      src_done  <= '0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      src_done <= '0;
      if (start) begin
        grant <= arb_gnt;
        idx   <= arb_idx;
        len   <= len_clamp;
        cnt   <= len_clamp;
        if (clamp) len_err <= 1'b1;
      end
      if (state == ST_PAY && wFIFO_wrreq) cnt <= cnt - 1'b1;
      if (frame_end) begin
        src_done  <= grant;
        grant     <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched: table of single frames plus hand-written
// back-pressure, reset and held-request sequences.
module tb_uart_frame_sched;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] req_len;
  logic [15:0] pl_data;
  logic [1:0]  grant;
  logic        pl_rd;
  logic [1:0]  src_done;
  logic [7:0]  wFIFO_idata;
  logic        wFIFO_wrreq;
  logic        wFIFO_full;
  logic        uart_send;
  logic        uart_send_done;
  logic        uart_rdy;
  logic        len_err;
  logic [15:0] frame_cnt;

  always #10 clk_50m = ~clk_50m;

  uart_frame_sched #(.N_SRC(2), .MAX_LEN(64)) dut (
    .clk_50m        (clk_50m),
    .rst_n          (rst_n),
    .req            (req),
    .req_len        (req_len),
    .pl_data        (pl_data),
    .grant          (grant),
    .pl_rd          (pl_rd),
    .src_done       (src_done),
    .wFIFO_idata    (wFIFO_idata),
    .wFIFO_wrreq    (wFIFO_wrreq),
    .wFIFO_full     (wFIFO_full),
    .uart_send      (uart_send),
    .uart_send_done (uart_send_done),
    .uart_rdy       (uart_rdy),
    .len_err        (len_err),
    .frame_cnt      (frame_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Source model: show-ahead byte stream, advanced by pl_rd on the granted source.
  int rd_ptr [2] = '{0, 0};

  function automatic logic [7:0] src_byte(input int s, input int k);
    if (s == 0) return 8'((k + 1) * 17);
    return 8'(8'h80 + k * 3);
  endfunction

  always_comb begin
    pl_data = '0;
    for (int i = 0; i < 2; i++) pl_data[8*i +: 8] = src_byte(i, rd_ptr[i]);
  end

  initial forever begin
    @(posedge clk_50m);
    for (int i = 0; i < 2; i++)
      if (pl_rd && grant[i]) rd_ptr[i] <= rd_ptr[i] + 1;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk_50m);
    cyc++;
  end

  // Monitor: captures FIFO writes and timing marks on the falling edge.
  logic [7:0] cap[$];
  int base = 0;
  int grant_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, send_cyc = 0;
  int send_cnt = 0, viol = 0;
  logic [1:0] gprev = '0;

  initial forever begin
    @(negedge clk_50m);
    if (grant != 0 && gprev == 0) grant_cyc = cyc;
    gprev = grant;
    if (wFIFO_wrreq) begin
      if (cap.size() == base) first_wr_cyc = cyc;
      cap.push_back(wFIFO_idata);
      last_wr_cyc = cyc;
    end
    if (uart_send) begin
      send_cyc = cyc;
      send_cnt++;
    end
    if (wFIFO_full && (wFIFO_wrreq || pl_rd)) viol++;
    if (pl_rd && !wFIFO_wrreq) viol++;
  end

  // UART model: done three cycles after send, busy in between.
  initial begin
    uart_send_done = 1'b0;
    uart_rdy       = 1'b1;
    forever begin
      @(negedge clk_50m);
      #1;
      if (uart_send) begin
        uart_rdy = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 uart_send_done = 1'b1;
        @(posedge clk_50m);
        #1;
        uart_send_done = 1'b0;
        uart_rdy       = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_50m);
      #1;
      if (grant != 0) ok = 1'b1;
    end
    chk("grant_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_pl_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_50m);
      #1;
      if (pl_rd) ok = 1'b1;
    end
    chk("pl_rd_timeout", 32'(ok), 32'd1);
  endtask

  int exp_fc = 0;

  task automatic finish_frame(input int idx, input logic [7:0] elen, input logic eerr,
                              input int off, input int sends0, input bit chk_t);
    bit got;
    logic [7:0] exp[$];
    logic [7:0] c;
    logic [31:0] act;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk_50m);
      #1;
      if (src_done != 0) got = 1'b1;
    end
    chk("src_done_timeout", 32'(got), 32'd1);
    if (!got) return;
    chk("src_done_onehot", 32'(src_done), 32'(1 << idx));
    chk("grant_drop", 32'(grant), 32'd0);
    exp.push_back(8'hAA);
    exp.push_back(8'h55);
    exp.push_back(8'(idx));
    exp.push_back(elen);
    c = 8'(idx) ^ elen;
    for (int k = 0; k < int'(elen); k++) begin
      exp.push_back(src_byte(idx, off + k));
      c = c ^ src_byte(idx, off + k);
    end
`ifdef UART_SCHED_CKSUM_EN
    exp.push_back(c);
`endif
    chk("frame_bytes", 32'(cap.size() - base), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      act = (base + k < cap.size()) ? 32'(cap[base + k]) : 32'hDEAD;
      chk($sformatf("byte%0d_src%0d", k, idx), act, 32'(exp[k]));
    end
    exp_fc++;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    chk("len_err", 32'(len_err), 32'(eerr));
    chk("pl_consumed", 32'(rd_ptr[idx] - off), 32'(elen));
    chk("send_count", 32'(send_cnt - sends0), 32'd1);
    if (chk_t) begin
      chk("send_after_last_wr", 32'(send_cyc - last_wr_cyc), 32'd1);
      chk("first_wr_with_grant", 32'(first_wr_cyc), 32'(grant_cyc));
      chk("wr_consecutive", 32'(last_wr_cyc - first_wr_cyc + 1), 32'(exp.size()));
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] len0;
    logic [7:0] len1;
    int         idx;
    logic [7:0] elen;
    logic       eerr;
  } vec_t;

  vec_t vt [8];

  initial begin
    bit ok;
    int off, s0, low;

    vt[0] = '{req: 2'b01, len0: 8'd3,   len1: 8'd0,  idx: 0, elen: 8'd3,  eerr: 1'b0};
    vt[1] = '{req: 2'b11, len0: 8'd2,   len1: 8'd4,  idx: 1, elen: 8'd4,  eerr: 1'b0};
    vt[2] = '{req: 2'b11, len0: 8'd2,   len1: 8'd4,  idx: 0, elen: 8'd2,  eerr: 1'b0};
    vt[3] = '{req: 2'b11, len0: 8'd1,   len1: 8'd5,  idx: 1, elen: 8'd5,  eerr: 1'b0};
    vt[4] = '{req: 2'b11, len0: 8'd6,   len1: 8'd1,  idx: 0, elen: 8'd6,  eerr: 1'b0};
    vt[5] = '{req: 2'b10, len0: 8'd9,   len1: 8'd0,  idx: 1, elen: 8'd0,  eerr: 1'b0};
    vt[6] = '{req: 2'b01, len0: 8'd200, len1: 8'd0,  idx: 0, elen: 8'd64, eerr: 1'b1};
    vt[7] = '{req: 2'b10, len0: 8'd0,   len1: 8'd64, idx: 1, elen: 8'd64, eerr: 1'b1};

    rst_n      = 1'b0;
    req        = '0;
    req_len    = '0;
    wFIFO_full = 1'b0;
    repeat (2) @(posedge clk_50m);
    @(negedge clk_50m);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_wrreq", 32'(wFIFO_wrreq), 32'd0);
    chk("rst_idata", 32'(wFIFO_idata), 32'd0);
    chk("rst_pl_rd", 32'(pl_rd), 32'd0);
    chk("rst_src_done", 32'(src_done), 32'd0);
    chk("rst_uart_send", 32'(uart_send), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk_50m);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      @(posedge clk_50m);
      #1;
      base    = cap.size();
      s0      = send_cnt;
      req     = vt[v].req;
      req_len = {vt[v].len1, vt[v].len0};
      wait_grant(ok);
      if (ok) begin
        chk($sformatf("grant_v%0d", v), 32'(grant), 32'(1 << vt[v].idx));
        off = rd_ptr[vt[v].idx];
        @(posedge clk_50m);
        #1 req = '0;
        finish_frame(vt[v].idx, vt[v].elen, vt[v].eerr, off, s0, 1'b1);
      end
    end

    // Back-pressure: FIFO full for five cycles in the middle of the payload.
    @(posedge clk_50m);
    #1;
    base    = cap.size();
    s0      = send_cnt;
    req     = 2'b01;
    req_len = {8'd0, 8'd10};
    wait_grant(ok);
    if (ok) begin
      off = rd_ptr[0];
      wait_pl_rd(ok);
      req = '0;
      @(posedge clk_50m);
      #1 wFIFO_full = 1'b1;
      low = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk_50m);
        #1;
        if (!wFIFO_wrreq && !pl_rd) low++;
      end
      @(posedge clk_50m);
      #1 wFIFO_full = 1'b0;
      chk("bp_low_cycles", 32'(low), 32'd5);
      @(negedge clk_50m);
      #1;
      chk("bp_resume_wrreq", 32'(wFIFO_wrreq), 32'd1);
      chk("bp_resume_pl_rd", 32'(pl_rd), 32'd1);
      finish_frame(0, 8'd10, 1'b1, off, s0, 1'b0);
      chk("bp_full_violations", 32'(viol), 32'd0);
    end

    // Reset for one cycle during PAY.
    @(posedge clk_50m);
    #1;
    req     = 2'b01;
    req_len = {8'd0, 8'd20};
    wait_grant(ok);
    if (ok) begin
      wait_pl_rd(ok);
      @(posedge clk_50m);
      #1;
      rst_n = 1'b0;
      req   = '0;
      @(posedge clk_50m);
      #1 rst_n = 1'b1;
      @(negedge clk_50m);
      #1;
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_wrreq", 32'(wFIFO_wrreq), 32'd0);
      chk("midrst_pl_rd", 32'(pl_rd), 32'd0);
      chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("midrst_len_err", 32'(len_err), 32'd0);
      exp_fc = 0;
    end

    // Requests held on both sources for four frames; pointer restarts at 0.
    @(posedge clk_50m);
    #1;
    base    = cap.size();
    req     = 2'b11;
    req_len = {8'd7, 8'd5};
    for (int f = 0; f < 4; f++) begin
      s0 = send_cnt;
      wait_grant(ok);
      if (!ok) break;
      chk($sformatf("rr_grant_f%0d", f), 32'(grant), 32'(1 << (f % 2)));
      off = rd_ptr[f % 2];
      if (f == 3) begin
        @(posedge clk_50m);
        #1 req = '0;
      end
      finish_frame(f % 2, (f % 2 == 0) ? 8'd5 : 8'd7, 1'b0, off, s0, 1'b1);
      base = cap.size();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_sched.md
# uart_frame_sched

Round-robin frame scheduler sharing the board's single UART upload path among N_SRC byte-stream sources. It grants one requester and writes a framed packet into the upload block's write FIFO: header, source ID, length, payload and optional checksum. It then pulses the upload's send strobe and waits for its send-done before re-arbitrating. It sits between the tactile frame producers (sensor scan, status, debug) and `uart_upload`.

## Interface
- N_SRC, 2 — number of requesters (2..8)
- MAX_LEN, 64 — maximum payload bytes per frame (1..255)
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  reset; one clock, synchronous and active-low
- req  in  N_SRC  per-source frame request, level
- req_len  in  8*N_SRC  per-source payload length, slice i = [8i+7:8i]
- pl_data  in  8*N_SRC  per-source show-ahead payload byte
- grant  out  N_SRC  one-hot grant, held for the whole frame
- pl_rd  out  1  consume strobe; the granted slice's byte is taken in the same cycle
- src_done  out  N_SRC  one-cycle pulse to the granted source when its frame has left the UART
- wFIFO_idata  out  8  byte to upload FIFO
- wFIFO_wrreq  out  1  FIFO write strobe, data valid in the same cycle
- wFIFO_full  in  1  FIFO full
- uart_send  out  1  one-cycle start-transmit pulse
- uart_send_done  in  1  upload finished (FIFO drained, last byte shifted)
- uart_rdy  in  1  upload idle
- len_err  out  1  sticky flag: a req_len above MAX_LEN was clamped; cleared only by reset
- frame_cnt  out  16  frames completed, wraps 0xFFFF→0

## Operation
- States: IDLE, HDR0, HDR1, ID, LEN, PAY, CKS, SEND, WAIT.
- IDLE: if uart_rdy=1 and req≠0, the round-robin winner is chosen.
  - Search starts at the index after the last granted source.
  - The pointer resets to 0, so source 0 wins first.
  - Latch `len = min(req_len, MAX_LEN)` and set len_err if clamped.
  - Assert grant and go to HDR0.
- Write states emit these bytes:
  - HDR0: 0xAA
  - HDR1: 0x55
  - ID: `{5'b0, idx}`
  - LEN: latched len
  - PAY: len payload bytes
  - CKS: checksum byte
- A write state asserts wFIFO_wrreq only when wFIFO_full=0. It advances only on a write cycle. It stalls indefinitely while full.
- PAY: pl_rd equals wFIFO_wrreq; wFIFO_idata is the granted pl_data slice. A down-counter stops the state after len writes. LEN goes straight to CKS (or SEND) when len=0.
- Checksum: 8-bit XOR of ID, LEN and all payload bytes. The header bytes are excluded.
- SEND: uart_send=1 for one cycle, then WAIT.
- WAIT: on uart_send_done=1, pulse src_done[idx], increment frame_cnt, clear grant, and return to IDLE.
  - uart_send_done is ignored in the SEND cycle itself.
- req deassertion after grant is ignored: the frame always completes. Requests arriving mid-frame wait for IDLE.
- Sources must hold req_len stable from request until grant.
- Reset mid-frame returns the block to IDLE and all outputs to reset values. Bytes already written are not flushed; `uart_upload` must be reset in the same cycle.
- Upload FIFO depth must be ≥ MAX_LEN+5. Bytes are written before uart_send, so a smaller FIFO deadlocks on full.

## Timing
- Reset values: grant=0, pl_rd=0, src_done=0, wFIFO_wrreq=0, wFIFO_idata=0, uart_send=0, len_err=0, frame_cnt=0, RR pointer=0.
- Request sampled in IDLE at cycle t: grant and the first wrreq (0xAA) at t+1.
- With FIFO never full: the frame occupies L+5 consecutive wrreq cycles (L+4 without checksum), then uart_send on the next cycle.
- src_done and grant deassertion occur in the same cycle, the cycle after uart_send_done is seen. IDLE re-arbitrates the following cycle.
- Minimum gap between two frames' uart_send pulses: the UART drain time plus L+7 cycles.

## Configuration
- UART_SCHED_CKSUM_EN defined: the CKS state exists and frames end with the XOR byte.
- Not defined: LEN/PAY go directly to SEND, the frame is 4+L bytes, and the checksum logic is absent.

## Structure
- Package `uart_sched_pkg`:
  - state enum
  - HDR0_BYTE=8'hAA, HDR1_BYTE=8'h55
  - ID width constant (3)
  - frame_cnt width
- Sub-module `rr_arbiter`: N_SRC request vector plus last-grant pointer in, one-hot grant and index out, combinational with registered pointer update on frame completion.

## Test plan
- Single frame: src0 req, len=3, payload 11 22 33, FIFO not full → FIFO receives AA 55 00 03 11 22 33 and checksum 0x03; one uart_send; after uart_send_done, src_done[0] pulses and frame_cnt=1.
- Round-robin: req=2'b11 held for 4 frames → grant order src0, src1, src0, src1, and each ID byte matches.
- Back-pressure: wFIFO_full forced high for 5 cycles during PAY → wrreq and pl_rd both low for exactly those cycles, and the byte sequence is intact.
- len=0 and len=200 with MAX_LEN=64 → header-only frame AA 55 id 00 cks; then a 64-byte payload with LEN byte 0x40 and len_err=1.
- Reset asserted in PAY for 1 cycle → next cycle state IDLE with grant=0, wrreq=0, frame_cnt=0 and RR pointer=0.
- Without UART_SCHED_CKSUM_EN: same stimulus as the first scenario → 7 bytes written, uart_send directly after 0x33.
